// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits at a time from the MSB
// and stops at the first differing chunk. Signed compares are folded into unsigned ones at capture.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  a_cap_reg;
    logic [WIDTH-1:0]  b_cap_reg;
    logic              done_reg;
    logic              eq_reg;
    logic              gt_reg;
    logic              lt_reg;

    logic [CHUNK-1:0]  a_chunk [NCHUNK];
    logic [CHUNK-1:0]  b_chunk [NCHUNK];
    logic [CHUNK-1:0]  cur_a;
    logic [CHUNK-1:0]  cur_b;
    logic              chunk_eq;
    logic              chunk_gt;
    logic              last_chunk;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_cap_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_cap_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign cur_a      = a_chunk[idx_reg];
    assign cur_b      = b_chunk[idx_reg];
    assign chunk_eq   = (cur_a == cur_b);
    assign chunk_gt   = (cur_a > cur_b);
    assign last_chunk = (idx_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN:  if (!chunk_eq || last_chunk) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == RUN);
        done   = done_reg;
        a_eq_b = eq_reg;
        a_gt_b = gt_reg;
        a_lt_b = lt_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg   <= '0;
            a_cap_reg <= '0;
            b_cap_reg <= '0;
            done_reg  <= 1'b0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    a_cap_reg <= a ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    b_cap_reg <= b ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    idx_reg   <= IDX_TOP;
                    eq_reg    <= 1'b0;
                    gt_reg    <= 1'b0;
                    lt_reg    <= 1'b0;
                end
            end else begin
                if (!chunk_eq) begin
                    gt_reg   <= chunk_gt;
                    lt_reg   <= !chunk_gt;
                    done_reg <= 1'b1;
                end else if (last_chunk) begin
                    eq_reg   <= 1'b1;
                    done_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: three instances (16/4, 5/1, 16/16) checked by a done-triggered scoreboard.
module tb_seq_comparator;
    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   dcyc;
    } exp_t;

    localparam int W [3] = '{16, 5, 16};
    localparam int C [3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        reset;
    logic        start_w [3];
    logic [15:0] a_w [3];
    logic [15:0] b_w [3];
    logic        sm_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        eq_w [3];
    logic        gt_w [3];
    logic        lt_w [3];

    exp_t scb [3][$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done [3];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_comparator #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_w[0]), .a(a_w[0]), .b(b_w[0]),
        .signed_mode(sm_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .a_eq_b(eq_w[0]), .a_gt_b(gt_w[0]), .a_lt_b(lt_w[0]));
    seq_comparator #(.WIDTH(5), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_w[1]), .a(a_w[1][4:0]), .b(b_w[1][4:0]),
        .signed_mode(sm_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .a_eq_b(eq_w[1]), .a_gt_b(gt_w[1]), .a_lt_b(lt_w[1]));
    seq_comparator #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_w[2]), .a(a_w[2]), .b(b_w[2]),
        .signed_mode(sm_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .a_eq_b(eq_w[2]), .a_gt_b(gt_w[2]), .a_lt_b(lt_w[2]));

    // Scoreboard monitor: every done pops one expectation and checks flags and arrival cycle.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) prev_done[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (done_w[d]) begin
                    total++;
                    if (scb[d].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d eq=%0b gt=%0b lt=%0b", d, cyc, eq_w[d], gt_w[d], lt_w[d]);
                    end else begin
                        mon_e = scb[d].pop_front();
                        if ({eq_w[d], gt_w[d], lt_w[d]} !== {mon_e.eq, mon_e.gt, mon_e.lt} || cyc != mon_e.dcyc) begin
                            bad++;
                            $display("FAIL result dut%0d got eq/gt/lt=%0b%0b%0b cyc=%0d expected %0b%0b%0b cyc=%0d",
                                     d, eq_w[d], gt_w[d], lt_w[d], cyc, mon_e.eq, mon_e.gt, mon_e.lt, mon_e.dcyc);
                        end else begin
                            $display("dut%0d done eq=%0b gt=%0b lt=%0b cyc=%0d ok", d, eq_w[d], gt_w[d], lt_w[d], cyc);
                        end
                    end
                    total++;
                    if (prev_done[d]) begin
                        bad++;
                        $display("FAIL double_done dut%0d cyc=%0d", d, cyc);
                    end
                end
                if (busy_w[d]) begin
                    total++;
                    if ({eq_w[d], gt_w[d], lt_w[d]} !== 3'b000) begin
                        bad++;
                        $display("FAIL flags_busy dut%0d got %0b%0b%0b expected 000", d, eq_w[d], gt_w[d], lt_w[d]);
                    end
                end
                prev_done[d] = done_w[d];
            end
        end
    end

    function automatic void model(input int w, input int c, input logic [15:0] av, input logic [15:0] bv,
                                  input logic sm, output logic eq, output logic gt, output logic lt, output int m);
        longint mask = (longint'(1) << w) - 1;
        longint ua = longint'(av) & mask;
        longint ub = longint'(bv) & mask;
        longint sa = ua;
        longint sb = ub;
        longint x = ua ^ ub;
        int h = -1;
        if (sm && ((ua >> (w - 1)) & 1) == 1) sa = ua - (longint'(1) << w);
        if (sm && ((ub >> (w - 1)) & 1) == 1) sb = ub - (longint'(1) << w);
        eq = (sa == sb);
        gt = (sa > sb);
        lt = (sa < sb);
        for (int i = 0; i < w; i++) if (((x >> i) & 1) == 1) h = i;
        m = (h < 0) ? (w / c) : (w / c - h / c);
    endfunction

    // Called at a negedge; start is sampled at the next rising edge.
    task automatic issue(input int d, input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         input logic push, input logic eq, input logic gt, input logic lt, input int m);
        a_w[d] = av;
        b_w[d] = bv;
        sm_w[d] = sm;
        start_w[d] = 1'b1;
        if (push) scb[d].push_back('{eq, gt, lt, cyc + 1 + m});
        @(negedge clk);
        start_w[d] = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (i < 200 && (scb[0].size() + scb[1].size() + scb[2].size()) != 0) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        total++;
        if ((scb[0].size() + scb[1].size() + scb[2].size()) != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d/%0d/%0d expected 0", scb[0].size(), scb[1].size(), scb[2].size());
            for (int d = 0; d < 3; d++) scb[d].delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_w[d] = 1'b0; a_w[d] = '0; b_w[d] = '0; sm_w[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({busy_w[d], done_w[d], eq_w[d], gt_w[d], lt_w[d]} !== 5'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d got %b expected 00000", d,
                         {busy_w[d], done_w[d], eq_w[d], gt_w[d], lt_w[d]});
            end
        end
        $display("test_reset complete");
    endtask

    task automatic test_equal();
        issue(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        issue(1, 16'h0014, 16'h0014, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        issue(2, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        drain();
    endtask

    task automatic test_msb();
        issue(0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        issue(1, 16'h0010, 16'h000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        issue(2, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        drain();
        issue(0, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        issue(1, 16'h0010, 16'h000F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        issue(2, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        drain();
    endtask

    task automatic test_early_exit();
        issue(0, 16'h12F0, 16'h1300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (busy_w[0] !== 1'b1 || {eq_w[0], gt_w[0], lt_w[0]} !== 3'b000) begin
                bad++;
                $display("FAIL early_busy cycle%0d got busy=%0b flags=%0b%0b%0b expected busy=1 flags=000",
                         k, busy_w[0], eq_w[0], gt_w[0], lt_w[0]);
            end
            @(negedge clk);
        end
        total++;
        if (busy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL early_busy_end got %0b expected 0", busy_w[0]);
        end
        drain();
    endtask

    task automatic test_busy_ignore();
        issue(0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4);
        issue(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        a_w[0] = 16'hFFFF;
        drain();
        total++;
        if (busy_w[0] !== 1'b0 || gt_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL ignore_hold got busy=%0b gt=%0b expected busy=0 gt=1", busy_w[0], gt_w[0]);
        end
    endtask

    task automatic test_reset_abort();
        issue(0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({busy_w[0], done_w[0], eq_w[0], gt_w[0], lt_w[0]} !== 5'b0) begin
            bad++;
            $display("FAIL abort_state got %b expected 00000", {busy_w[0], done_w[0], eq_w[0], gt_w[0], lt_w[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
                bad++;
                $display("FAIL abort_done cycle%0d got done=%0b busy=%0b expected 0/0", k, done_w[0], busy_w[0]);
            end
            @(negedge clk);
        end
        issue(0, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        total++;
        if (busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL first_start_after_reset got busy=%0b expected 1", busy_w[0]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        issue(0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        @(negedge clk);
        total++;
        if (done_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got %0b expected 1", done_w[0]);
        end
        issue(0, 16'h0005, 16'h0050, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        total++;
        if (busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept got busy=%0b expected 1", busy_w[0]);
        end
        drain();
    endtask

    task automatic test_random();
        logic [15:0] av, bv;
        logic sm, eq, gt, lt;
        int m;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 10; n++) begin
                av = 16'($urandom);
                case ($urandom_range(0, 2))
                    0: bv = av;
                    1: bv = av ^ (16'h1 << $urandom_range(0, W[d] - 1));
                    default: bv = 16'($urandom);
                endcase
                sm = 1'($urandom_range(0, 1));
                model(W[d], C[d], av, bv, sm, eq, gt, lt, m);
                issue(d, av, bv, sm, 1'b1, eq, gt, lt, m);
                drain();
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_early_exit();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a comparison; sampled on clk edge.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled only when start is accepted.
REQ-009 SHALL have port busy  output  1  comparison in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port a_eq_b  output  1  registered result, A == B.
REQ-012 SHALL have port a_gt_b  output  1  registered result, A > B.
REQ-013 SHALL have port a_lt_b  output  1  registered result, A < B.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1).
REQ-015 IDLE with start=1 at an edge SHALL:
- capture a, b and signed_mode;
- set chunk index idx to NCHUNK-1 (MSB chunk);
- clear all three result flags to 0;
- enter RUN.
REQ-016 In signed mode, the MSB of both captured operands SHALL be inverted at capture so the RUN datapath is purely an unsigned compare.
REQ-017 RUN SHALL compare chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of the captured operands at each edge.
REQ-018 If the chunks differ, the same edge SHALL:
- set a_gt_b or a_lt_b accordingly;
- pulse done=1 for the next cycle;
- return to IDLE (early termination).
REQ-019 If the chunks are equal and idx==0, the same edge SHALL:
- set a_eq_b=1;
- pulse done;
- return to IDLE.
REQ-020 If the chunks are equal and idx>0, the edge SHALL decrement idx and remain in RUN.
REQ-021 Latency SHALL be m cycles from the accepting edge to done high, where m (1..NCHUNK) is the number of chunks examined; equal operands SHALL take exactly NCHUNK cycles.
REQ-022 Result flags SHALL be one-hot after any completion and SHALL hold until the next accepted start.
REQ-023 Flags SHALL be all-zero while busy.
REQ-024 start while busy SHALL be ignored, with no effect on the in-flight comparison.
REQ-025 Changes on a, b and signed_mode while busy SHALL NOT affect the result.
REQ-026 start asserted in the cycle done is high SHALL be accepted (busy is 0 then), giving back-to-back operation with no dead cycle.
REQ-027 done SHALL never be high for two consecutive cycles from a single comparison.
REQ-028 CHUNK==WIDTH SHALL give single-cycle comparisons (m=1 always).

Reset
REQ-029 reset asserted SHALL immediately force:
- state IDLE;
- busy=0, done=0;
- a_eq_b=0, a_gt_b=0, a_lt_b=0;
- idx=0.
REQ-030 reset asserted mid-comparison SHALL abort it, and no done pulse SHALL be produced for the aborted operation.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 Bench SHALL drive unsigned a=0x1234, b=0x1234 -> done 4 cycles after the accepting edge, a_eq_b=1, others 0.
REQ-033 Bench SHALL drive a=0x8000, b=0x7FFF:
- signed_mode=0 -> a_gt_b=1 after 1 cycle;
- signed_mode=1 -> a_lt_b=1 after 1 cycle.
REQ-034 Bench SHALL drive a=0x12F0, b=0x1300 unsigned -> a_lt_b=1 after 2 cycles; busy high 2 cycles; flags 0 while busy.
REQ-035 Bench SHALL start a=0x0001, b=0x0000, then on the next cycles change a to 0xFFFF and pulse start -> second start ignored; result a_gt_b=1 after 4 cycles.
REQ-036 Bench SHALL assert reset 2 cycles into an equal-operand compare -> busy, done and flags all 0 immediately; no done follows.
REQ-037 Bench SHALL issue a new start in a done cycle -> accepted; and SHALL rerun REQ-032/033 with WIDTH=5, CHUNK=1 (done after 5 cycles for equal operands) and with CHUNK=16 (done always after 1 cycle).
